// File: rtl/ccip_soft_reset_pkg.sv
// ----------------------------------------------------------------------------
// ccip_soft_reset_pkg
// Shared types and helpers for the CCI-P AFU soft-reset generator.
//   t_soft_reset_state : FSM encoding (IDLE, DRAIN, ASSERT)
//   t_inflight_cnt     : per-channel in-flight counter at the default width
//   cnt_w()            : bit width needed by a counter that runs 0..n-1
// ----------------------------------------------------------------------------
package ccip_soft_reset_pkg;

  localparam int MIN_RESET_CYCLES_DEFAULT = 16;
  localparam int DRAIN_TIMEOUT_DEFAULT    = 4096;
  localparam int CNT_W_DEFAULT            = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    ASSERT = 2'd2
  } t_soft_reset_state;

  typedef logic [CNT_W_DEFAULT-1:0] t_inflight_cnt;

  // Width of a counter whose terminal value is terminal_count-1.
  function automatic int cnt_w(input int terminal_count);
    return (terminal_count < 2) ? 1 : $clog2(terminal_count);
  endfunction

endpackage

// File: rtl/ccip_inflight_counter.sv
// ----------------------------------------------------------------------------
// ccip_inflight_counter
// Saturating up/down counter tracking outstanding requests on one channel.
//   clk      : clock
//   reset_n  : synchronous active-low reset (count -> 0)
//   clr      : synchronous clear (count -> 0)
//   inc      : request issued  (+1, holds at all-ones)
//   dec      : response received (-1, holds at zero)
//   count    : current outstanding count
// inc and dec in the same cycle cancel out.
// ----------------------------------------------------------------------------
module ccip_inflight_counter
  import ccip_soft_reset_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      count <= '0;
    end else if (inc && !dec && count != CNT_MAX) begin
      count <= count + W'(1);
    end else if (dec && !inc && count != '0) begin
      // Clamp at zero: a spurious response must never wrap to all-ones.
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/ccip_soft_reset_gen.sv
// ----------------------------------------------------------------------------
// ccip_soft_reset_gen
// FIU-side producer of the AFU soft reset. On request it blocks new AFU
// traffic, waits for in-flight c0/c1 requests to drain, holds soft reset high
// for MIN_RESET_CYCLES, then releases.
//   pClk                : CCI-P primary clock
//   reset_n             : synchronous active-low block reset
//   rst_req             : 1-cycle soft-reset request (ignored unless IDLE)
//   c0_req_sent/rsp_rcvd: c0 read request issued / response delivered
//   c1_req_sent/rsp_rcvd: c1 write request issued / response delivered
//   tx_block            : AFU must not issue new requests
//   pck_cp2af_softReset : active-high soft reset to the AFU
//   reset_done          : 1-cycle pulse in the first cycle after release
//   busy                : FSM not IDLE
//   inflight            : c0 count + c1 count
//   drain_timeout       : sticky, a drain was cut short by the timeout
// Build option: define CCIP_SOFT_RESET_TIMEOUT_EN to bound the DRAIN phase to
// DRAIN_TIMEOUT cycles; otherwise DRAIN waits indefinitely.
// ----------------------------------------------------------------------------
module ccip_soft_reset_gen
  import ccip_soft_reset_pkg::*;
#(
  parameter int MIN_RESET_CYCLES = MIN_RESET_CYCLES_DEFAULT,
  parameter int DRAIN_TIMEOUT    = DRAIN_TIMEOUT_DEFAULT,
  parameter int CNT_W            = CNT_W_DEFAULT
) (
  input  logic           pClk,
  input  logic           reset_n,
  input  logic           rst_req,
  input  logic           c0_req_sent,
  input  logic           c0_rsp_rcvd,
  input  logic           c1_req_sent,
  input  logic           c1_rsp_rcvd,
  output logic           tx_block,
  output logic           pck_cp2af_softReset,
  output logic           reset_done,
  output logic           busy,
  output logic [CNT_W:0] inflight,
  output logic           drain_timeout
);

  localparam int                HOLD_W    = cnt_w(MIN_RESET_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_RESET_CYCLES - 1);

  t_soft_reset_state state, state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  c0_cnt, c1_cnt;
  logic              cnt_clr;

  // Counters read zero from the first ASSERT cycle and stay there until
  // release, so traffic seen while the AFU is in reset is discarded.
  assign cnt_clr = (state == ASSERT) || (state_next == ASSERT);

  ccip_inflight_counter #(.W(CNT_W)) u_c0_cnt (
    .clk     (pClk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (c0_req_sent),
    .dec     (c0_rsp_rcvd),
    .count   (c0_cnt)
  );

  ccip_inflight_counter #(.W(CNT_W)) u_c1_cnt (
    .clk     (pClk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (c1_req_sent),
    .dec     (c1_rsp_rcvd),
    .count   (c1_cnt)
  );

  assign inflight = {1'b0, c0_cnt} + {1'b0, c1_cnt};

`ifdef CCIP_SOFT_RESET_TIMEOUT_EN
  localparam int                 DRAIN_W    = cnt_w(DRAIN_TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

  logic [DRAIN_W-1:0] drain_cnt;
  logic               drain_expired;

  assign drain_expired = (drain_cnt == DRAIN_LAST);

  always_ff @(posedge pClk) begin
    if (!reset_n) begin
      drain_cnt     <= '0;
      drain_timeout <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
      if (state == DRAIN && inflight != '0 && drain_expired) begin
        drain_timeout <= 1'b1;
      end
    end
  end
`else
  // The timeout parameter stays on the interface so both builds share one
  // instantiation; this build has no drain counter.
  logic unused_drain_timeout_cfg;
  assign unused_drain_timeout_cfg = (DRAIN_TIMEOUT > 0);
  assign drain_timeout            = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (rst_req) state_next = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0) state_next = ASSERT;
`ifdef CCIP_SOFT_RESET_TIMEOUT_EN
        else if (drain_expired) state_next = ASSERT;
`endif
      end
      ASSERT: begin
        if (hold_cnt == HOLD_LAST) state_next = IDLE;
      end
      default: state_next = ASSERT;
    endcase
  end

  always_ff @(posedge pClk) begin
    if (!reset_n) begin
      state      <= ASSERT;
      hold_cnt   <= '0;
      reset_done <= 1'b0;
    end else begin
      state      <= state_next;
      // hold_cnt restarts at 0 on every ASSERT entry and runs to HOLD_LAST.
      hold_cnt   <= (state == ASSERT && state_next == ASSERT) ? hold_cnt + HOLD_W'(1) : '0;
      reset_done <= (state == ASSERT) && (state_next == IDLE);
    end
  end

  assign pck_cp2af_softReset = (state == ASSERT);
  assign tx_block            = (state != IDLE);
  assign busy                = (state != IDLE);

endmodule

// File: tb/tb_ccip_soft_reset_gen.sv
// ----------------------------------------------------------------------------
// tb_ccip_soft_reset_gen
// Directed bench for ccip_soft_reset_gen. Stimulus pushes the expected
// reset_done cycle, soft-reset width and drain_timeout flag into a queue; a
// monitor pops and compares on every reset_done pulse. Counter and phase
// checks are made inline. Timeout expectations follow the
// CCIP_SOFT_RESET_TIMEOUT_EN build option.
// ----------------------------------------------------------------------------
module tb_ccip_soft_reset_gen;
  import ccip_soft_reset_pkg::*;

  localparam int MIN_RC = 16;
  localparam int CW     = 10;

  logic          pClk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rst_req = 1'b0;
  logic          c0_req_sent = 1'b0, c0_rsp_rcvd = 1'b0;
  logic          c1_req_sent = 1'b0, c1_rsp_rcvd = 1'b0;
  logic          tx_block, pck_cp2af_softReset, reset_done, busy, drain_timeout;
  logic [CW:0]   inflight;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    int   cyc;
    int   hi;
    logic dto;
  } exp_t;
  exp_t exp_q[$];

  ccip_soft_reset_gen #(
    .MIN_RESET_CYCLES (MIN_RC),
    .DRAIN_TIMEOUT    (64),
    .CNT_W            (CW)
  ) dut (
    .pClk                (pClk),
    .reset_n             (reset_n),
    .rst_req             (rst_req),
    .c0_req_sent         (c0_req_sent),
    .c0_rsp_rcvd         (c0_rsp_rcvd),
    .c1_req_sent         (c1_req_sent),
    .c1_rsp_rcvd         (c1_rsp_rcvd),
    .tx_block            (tx_block),
    .pck_cp2af_softReset (pck_cp2af_softReset),
    .reset_done          (reset_done),
    .busy                (busy),
    .inflight            (inflight),
    .drain_timeout       (drain_timeout)
  );

  always #5 pClk = ~pClk;
  always @(posedge pClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus: inputs change 1 time unit after the active edge.
  task automatic drive(input logic rr, input logic c0s, input logic c0r,
                       input logic c1s, input logic c1r);
    @(posedge pClk); #1;
    rst_req     = rr;
    c0_req_sent = c0s;
    c0_rsp_rcvd = c0r;
    c1_req_sent = c1s;
    c1_rsp_rcvd = c1r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Holds reset_n low for n cycles; returns in the first released cycle.
  task automatic reset_low(input int n);
    @(posedge pClk); #1;
    reset_n = 1'b0;
    {rst_req, c0_req_sent, c0_rsp_rcvd, c1_req_sent, c1_rsp_rcvd} = '0;
    repeat (n - 1) begin
      @(posedge pClk); #1;
    end
    @(posedge pClk); #1;
    reset_n = 1'b1;
  endtask

  task automatic expect_done(input int at_cyc, input logic dto);
    exp_t e;
    e.cyc = at_cyc;
    e.hi  = MIN_RC;
    e.dto = dto;
    exp_q.push_back(e);
  endtask

  // Monitor: measures the soft-reset high run and scores every reset_done.
  initial begin
    int   hi_len;
    exp_t e;
    hi_len = 0;
    forever begin
      @(negedge pClk);
      if (!reset_n) begin
        hi_len = 0;
      end else begin
        if (pck_cp2af_softReset === 1'b1) hi_len++;
        if (reset_done === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("spurious_reset_done", 32'(reset_done), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("done_cycle",      cyc,                 e.cyc);
            check("softreset_width", hi_len,              e.hi);
            check("done_timeout",    32'(drain_timeout),  32'(e.dto));
            check("done_softreset",  32'(pck_cp2af_softReset), 32'd0);
            check("done_tx_block",   32'(tx_block),       32'd0);
            check("done_busy",       32'(busy),           32'd0);
          end
          hi_len = 0;
        end
      end
    end
  end

  initial begin
    int            t;
    t_inflight_cnt max_cnt;
    max_cnt = '1;

    // Release from reset: 16 cycles of soft reset, then one reset_done.
    reset_low(5);
    t = cyc;
    expect_done(t + MIN_RC, 1'b0);
    @(negedge pClk);
    check("rst_softreset",  32'(pck_cp2af_softReset), 32'd1);
    check("rst_tx_block",   32'(tx_block),            32'd1);
    check("rst_busy",       32'(busy),                32'd1);
    check("rst_done",       32'(reset_done),          32'd0);
    check("rst_inflight",   32'(inflight),            32'd0);
    check("rst_timeout",    32'(drain_timeout),       32'd0);
    idle(20);
    check("post_rst_txblk", 32'(tx_block),            32'd0);

    // Request with nothing in flight.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    t = cyc;
    expect_done(t + 18, 1'b0);
    @(negedge pClk);
    check("idle_req_txblk_T", 32'(tx_block), 32'd0);
    idle(1);
    @(negedge pClk);
    check("idle_req_txblk_T1", 32'(tx_block),            32'd1);
    check("idle_req_sr_T1",    32'(pck_cp2af_softReset), 32'd0);
    idle(1);
    @(negedge pClk);
    check("idle_req_sr_T2",    32'(pck_cp2af_softReset), 32'd1);
    idle(20);

    // Drain: 3 c0 + 2 c1 outstanding, responses every 4 cycles.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    t = cyc;
    expect_done(t + 36, 1'b0);
    @(negedge pClk);
    check("drain_inflight_5", 32'(inflight), 32'd5);
    idle(1);
    @(negedge pClk);
    check("drain_txblk", 32'(tx_block), 32'd1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, (k < 3), 1'b0, (k >= 3));
      idle(1);
      @(negedge pClk);
      check("drain_inflight", 32'(inflight), 32'(4 - k));
      check("drain_sr_low",   32'(pck_cp2af_softReset), 32'd0);
      idle(2);
    end
    @(negedge pClk);
    check("drain_sr_after_zero", 32'(pck_cp2af_softReset), 32'd1);
    idle(20);

    // Simultaneous request/response and saturation.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    @(negedge pClk);
    check("both_at_0", 32'(inflight), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    @(negedge pClk);
    check("rsp_at_0", 32'(inflight), 32'd0);
    repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    @(negedge pClk);
    check("both_at_5", 32'(inflight), 32'd5);
    repeat (1018) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    @(negedge pClk);
    check("count_1023", 32'(inflight), 32'(max_cnt));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    @(negedge pClk);
    check("req_at_max", 32'(inflight), 32'(max_cnt));
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    @(negedge pClk);
    check("both_at_max", 32'(inflight), 32'(max_cnt));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    @(negedge pClk);
    check("sum_1024", 32'(inflight), 32'd1024);

    // reset_n clears counters; traffic during ASSERT is ignored.
    reset_low(2);
    t = cyc;
    expect_done(t + MIN_RC, 1'b0);
    @(negedge pClk);
    check("clr_inflight", 32'(inflight), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    @(negedge pClk);
    check("assert_ignores_req", 32'(inflight), 32'd0);
    idle(20);
    check("post_assert_inflight", 32'(inflight), 32'd0);

    // Repeated rst_req during DRAIN and ASSERT coalesces into one reset.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    t = cyc;
    expect_done(t + 20, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(20);
    check("coalesce_idle", 32'(busy), 32'd0);

    // reset_n mid-ASSERT restarts a full-width assertion.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);
    reset_low(1);
    t = cyc;
    expect_done(t + MIN_RC, 1'b0);
    idle(20);

    // One c0 request never answered.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    t = cyc;
`ifdef CCIP_SOFT_RESET_TIMEOUT_EN
    expect_done(t + 81, 1'b1);
    idle(64);
    @(negedge pClk);
    check("to_last_drain_sr",  32'(pck_cp2af_softReset), 32'd0);
    check("to_last_drain_flg", 32'(drain_timeout),       32'd0);
    idle(1);
    @(negedge pClk);
    check("to_assert_sr",       32'(pck_cp2af_softReset), 32'd1);
    check("to_assert_flag",     32'(drain_timeout),       32'd1);
    check("to_assert_inflight", 32'(inflight),            32'd0);
    idle(25);
    @(negedge pClk);
    check("to_flag_sticky", 32'(drain_timeout), 32'd1);
    check("to_busy_low",    32'(busy),          32'd0);
    reset_low(2);
    @(negedge pClk);
    check("to_flag_cleared", 32'(drain_timeout), 32'd0);
`else
    begin
      int highs;
      highs = 0;
      repeat (200) begin
        idle(1);
        @(negedge pClk);
        if (pck_cp2af_softReset !== 1'b0) highs++;
      end
      check("stuck_no_softreset", highs,                32'd0);
      check("stuck_busy",         32'(busy),            32'd1);
      check("stuck_inflight",     32'(inflight),        32'd1);
      check("stuck_no_timeout",   32'(drain_timeout),   32'd0);
    end
    reset_low(2);
`endif
    t = cyc;
    expect_done(t + MIN_RC, 1'b0);
    idle(20);

    idle(3);
    check("all_done_seen", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
